mux_nx1_seq: RTL and testbench

Parametrised, registered N:1 multiplexer for the 8-bit ALU datapath. Replaces the fixed combinational 8x1 bit mux with a WIDTH-bit, N-channel selector that has a valid/ready output register. Two modes: direct (the caller supplies the select) and scan (an internal FSM walks every channel in order). Sits between the operand/result banks and downstream consumers that may stall.

---
 rtl/mux_nx1_seq_if.sv | 32 +++
 rtl/mux_nx1_seq.sv | 130 +++++++++++++
 tb/tb_mux_nx1_seq.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_nx1_seq_if.sv
// Bus bundle for mux_nx1_seq: packed input channels, direct-select handshake,
// scan control and the registered valid/ready output.
interface mux_nx1_seq_if #(
  parameter int WIDTH = 8,
  parameter int N     = 8
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] i;
  logic [SEL_W-1:0]   s;
  logic               s_valid;
  logic               s_ready;
  logic               mode;
  logic               start;
  logic [WIDTH-1:0]   y;
  logic [SEL_W-1:0]   y_ch;
  logic               y_valid;
  logic               y_ready;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output i, s, s_valid, mode, start, y_ready,
    input  s_ready, y, y_ch, y_valid, busy, done, err
  );

  modport slave (
    input  i, s, s_valid, mode, start, y_ready,
    output s_ready, y, y_ch, y_valid, busy, done, err
  );
endinterface

// File: rtl/mux_nx1_seq.sv
// Registered N:1 channel selector with a valid/ready output register.
// Direct mode loads the caller-selected channel; scan mode walks the channels
// in ascending order under FSM control, stalling on output backpressure.
// Optional build macro MUX_SCAN_MASK_EN adds scan_mask: only enabled channels
// are scanned, and an all-zero mask completes the scan without emitting.
module mux_nx1_seq #(
  parameter int WIDTH = 8,
  parameter int N     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0] scan_mask,
`endif
  mux_nx1_seq_if.slave bus
);
  localparam int SEL_W = $clog2(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // N widened by one bit so selects at or beyond N are detectable
  localparam logic [SEL_W:0] N_W = (SEL_W+1)'(N);

  logic [1:0]              state;
  logic [SEL_W-1:0]        cnt;
  logic [N-1:0][WIDTH-1:0] ch;
  logic [N-1:0]            mask;     // mask in force during SCAN
  logic [N-1:0]            mask_st;  // mask seen at start
  logic                    can_load, start_go, dir_fire, oor, load;
  logic [SEL_W-1:0]        sel, first, nxt;
  logic                    first_ok, nxt_ok;
  logic [WIDTH-1:0]        sel_data;

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch[k] = bus.i[k*WIDTH +: WIDTH];
  end

`ifdef MUX_SCAN_MASK_EN
  logic [N-1:0] mask_q;

  // capture the scan mask at start; it governs the whole scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mask_q <= '0;
    else if (start_go) mask_q <= scan_mask;
  end

  assign mask    = mask_q;
  assign mask_st = scan_mask;
`else
  assign mask    = '1;
  assign mask_st = '1;
`endif

  assign can_load    = !bus.y_valid || bus.y_ready;
  assign bus.s_ready = (state == IDLE) && !bus.mode && can_load;
  assign dir_fire    = bus.s_valid && bus.s_ready;
  assign start_go    = (state == IDLE) && bus.mode && bus.start;
  assign oor         = {1'b0, bus.s} >= N_W;
  assign load        = dir_fire || ((state == SCAN) && can_load);
  assign sel         = (state == SCAN) ? cnt : bus.s;
  assign bus.busy    = (state == SCAN);
  assign bus.done    = (state == DONE);

  // first enabled channel, next enabled channel above cnt, and the data mux;
  // an out-of-range select matches no channel and yields zero
  always_comb begin
    first    = '0;
    first_ok = 1'b0;
    nxt      = '0;
    nxt_ok   = 1'b0;
    sel_data = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (mask_st[k]) begin
        first    = SEL_W'(k);
        first_ok = 1'b1;
      end
      if (mask[k] && (k > int'(cnt))) begin
        nxt    = SEL_W'(k);
        nxt_ok = 1'b1;
      end
    end
    for (int k = 0; k < N; k++)
      if (int'(sel) == k) sel_data = ch[k];
  end

  // scan FSM: the counter only advances when a word is actually loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start_go) begin
          state <= first_ok ? SCAN : DONE;
          cnt   <= first;
        end
        SCAN: if (can_load) begin
          if (nxt_ok) cnt <= nxt;
          else begin
            state <= DONE;
            cnt   <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // output register: holds under backpressure, drain and load may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y       <= '0;
      bus.y_ch    <= '0;
      bus.y_valid <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.err <= dir_fire && oor;
      if (load) begin
        bus.y       <= sel_data;
        bus.y_ch    <= sel;
        bus.y_valid <= 1'b1;
      end else if (bus.y_ready) begin
        bus.y_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_nx1_seq.sv
// Scoreboard bench for mux_nx1_seq: an N=8 and an N=6 instance. Stimulus pushes
// expected {y, y_ch} words; monitors pop and compare on every output handshake.
module tb_mux_nx1_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_nx1_seq_if #(.WIDTH(8), .N(8)) b8();
  mux_nx1_seq_if #(.WIDTH(8), .N(6)) b6();

`ifdef MUX_SCAN_MASK_EN
  logic [7:0] mask8;
  logic [5:0] mask6;
`endif

  mux_nx1_seq #(.WIDTH(8), .N(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MUX_SCAN_MASK_EN
    .scan_mask(mask8),
`endif
    .bus(b8)
  );

  mux_nx1_seq #(.WIDTH(8), .N(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
`ifdef MUX_SCAN_MASK_EN
    .scan_mask(mask6),
`endif
    .bus(b6)
  );

  typedef struct packed {logic [7:0] y; logic [2:0] ch;} exp_t;
  exp_t q8[$];
  exp_t q6[$];
  exp_t e8, e6;
  int nchk = 0, nerr = 0;
  int ndone8 = 0, ndone6 = 0, nbusy8 = 0, npop8 = 0, nv6 = 0;

  function automatic void chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(int y, int c);
    return {8'(y), 3'(c)};
  endfunction

  // monitors: compare on each handshake, count done/busy/valid cycles
  always @(negedge clk) begin
    if (rst_n) begin
      if (b8.done) ndone8++;
      if (b8.busy) nbusy8++;
      if (b6.done) ndone6++;
      if (b6.y_valid) nv6++;
      if (b8.y_valid && b8.y_ready) begin
        if (q8.size() == 0) chk("sb8_unexpected_word", q8.size(), 1);
        else begin
          e8 = q8.pop_front();
          chk("y8", b8.y, e8.y);
          chk("ych8", b8.y_ch, e8.ch);
          npop8++;
        end
      end
      if (b6.y_valid && b6.y_ready) begin
        if (q6.size() == 0) chk("sb6_unexpected_word", q6.size(), 1);
        else begin
          e6 = q6.pop_front();
          chk("y6", b6.y, e6.y);
          chk("ych6", b6.y_ch, e6.ch);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i8(int base);
    for (int k = 0; k < 8; k++) b8.i[k*8 +: 8] = 8'(base + k);
  endtask

  task automatic set_i6(int base);
    for (int k = 0; k < 6; k++) b6.i[k*8 +: 8] = 8'(base + k);
  endtask

  task automatic drain(bit six, string nm);
    for (int c = 0; c < 40; c++) begin
      if ((six ? q6.size() : q8.size()) == 0) break;
      tick();
    end
    chk(nm, six ? q6.size() : q8.size(), 0);
    tick();
    tick();
  endtask

  // wait (bounded) for one done pulse, then confirm it was exactly one
  task automatic wait_done(bit six, int d0, string nm);
    for (int c = 0; c < 60; c++) begin
      if ((six ? ndone6 : ndone8) != d0) break;
      tick();
    end
    tick();
    tick();
    chk(nm, (six ? ndone6 : ndone8) - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, p0, v0;
    b8.s = '0; b8.s_valid = 0; b8.mode = 0; b8.start = 0; b8.y_ready = 1;
    b6.s = '0; b6.s_valid = 0; b6.mode = 0; b6.start = 0; b6.y_ready = 1;
    set_i8(8'hA0);
    set_i6(8'hA0);
`ifdef MUX_SCAN_MASK_EN
    mask8 = '1;
    mask6 = '1;
`endif
    #3;
    chk("rst_y", b8.y, 0);
    chk("rst_ych", b8.y_ch, 0);
    chk("rst_yvalid", b8.y_valid, 0);
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_err", b8.err, 0);
    #9 rst_n = 1'b1;
    tick();

    // 1: direct, every channel back to back
    for (int s = 0; s < 8; s++) begin
      b8.s = 3'(s);
      b8.s_valid = 1;
      q8.push_back(mk(8'hA0 + s, s));
      #1 chk("sready_t1", b8.s_ready, 1);
      tick();
      chk("err_t1", b8.err, 0);
    end
    b8.s_valid = 0;
    drain(0, "drain_t1");

    // 2: backpressure holds the register while inputs churn
    b8.s = 3'd3; b8.s_valid = 1;
    q8.push_back(mk(8'hA3, 3));
    tick();
    b8.y_ready = 0; b8.s = 3'd5;
    set_i8(8'hB0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("sready_t2", b8.s_ready, 0);
      chk("yhold_t2", b8.y, 8'hA3);
      chk("ychhold_t2", b8.y_ch, 3);
      chk("yvalid_t2", b8.y_valid, 1);
      tick();
    end
    b8.y_ready = 1;
    q8.push_back(mk(8'hB5, 5));
    #1 chk("sready_t2b", b8.s_ready, 1);
    tick();
    b8.s_valid = 0;
    set_i8(8'hA0);
    drain(0, "drain_t2");

    // 3: full scan, no backpressure; direct requests ignored meanwhile
    b8.mode = 1; b8.start = 1; b8.s_valid = 1; b8.s = 3'd2;
    d0 = ndone8; b0 = nbusy8;
    for (int k = 0; k < 8; k++) q8.push_back(mk(8'hA0 + k, k));
    tick();
    b8.start = 0;
    #1 chk("sready_scan", b8.s_ready, 0);
    wait_done(0, d0, "done_t3");
    chk("busy_cycles_t3", nbusy8 - b0, 8);
    b8.s_valid = 0;
    drain(0, "drain_t3");

    // 4: scan with y_ready toggling every cycle
    b8.start = 1;
    d0 = ndone8;
    for (int k = 0; k < 8; k++) q8.push_back(mk(8'hA0 + k, k));
    tick();
    b8.start = 0;
    for (int c = 0; c < 60; c++) begin
      if (ndone8 != d0) break;
      b8.y_ready = ~b8.y_ready;
      tick();
    end
    b8.y_ready = 1;
    tick();
    tick();
    chk("done_t4", ndone8 - d0, 1);
    drain(0, "drain_t4");

    // 5: asynchronous reset mid-scan, then a fresh scan from channel 0
    b8.start = 1;
    p0 = npop8;
    for (int k = 0; k < 8; k++) q8.push_back(mk(8'hA0 + k, k));
    tick();
    b8.start = 0;
    for (int c = 0; c < 20; c++) begin
      if (npop8 >= p0 + 3) break;
      tick();
    end
    chk("words_before_rst", npop8 - p0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", b8.y, 0);
    chk("arst_ych", b8.y_ch, 0);
    chk("arst_yvalid", b8.y_valid, 0);
    chk("arst_busy", b8.busy, 0);
    chk("arst_done", b8.done, 0);
    q8.delete();
    #3 rst_n = 1'b1;
    tick();
    chk("idle_busy_t5", b8.busy, 0);
    chk("idle_done_t5", b8.done, 0);
    b8.start = 1;
    d0 = ndone8;
    for (int k = 0; k < 8; k++) q8.push_back(mk(8'hA0 + k, k));
    tick();
    b8.start = 0;
    wait_done(0, d0, "done_t5");
    drain(0, "drain_t5");
    b8.mode = 0;

    // 6: N=6, out-of-range select and in-range select
    b6.s = 3'd7; b6.s_valid = 1;
    q6.push_back(mk(0, 7));
    tick();
    b6.s = 3'd4;
    q6.push_back(mk(8'hA4, 4));
    chk("err_oor", b6.err, 1);
    chk("yvalid_oor", b6.y_valid, 1);
    chk("y_oor", b6.y, 0);
    chk("ych_oor", b6.y_ch, 7);
    tick();
    b6.s_valid = 0;
    chk("err_pulse_end", b6.err, 0);
    drain(1, "drain_t6a");

`ifdef MUX_SCAN_MASK_EN
    mask6 = 6'b100101;
    b6.mode = 1; b6.start = 1;
    d0 = ndone6;
    q6.push_back(mk(8'hA0, 0));
    q6.push_back(mk(8'hA2, 2));
    q6.push_back(mk(8'hA5, 5));
    tick();
    b6.start = 0;
    wait_done(1, d0, "done_mask");
    drain(1, "drain_mask");
    mask6 = '0;
    v0 = nv6;
    b6.start = 1;
    d0 = ndone6;
    tick();
    b6.start = 0;
    wait_done(1, d0, "done_mask0");
    chk("novalid_mask0", nv6 - v0, 0);
`else
    b6.mode = 1; b6.start = 1;
    d0 = ndone6;
    for (int k = 0; k < 6; k++) q6.push_back(mk(8'hA0 + k, k));
    tick();
    b6.start = 0;
    wait_done(1, d0, "done_scan6");
    drain(1, "drain_scan6");
    v0 = nv6;
    tick();
    chk("idle_valid6", nv6 - v0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
